rr_arb_mux: RTL and testbench



---
 rtl/rr_arb_mux.sv | 93 +++++++++
 tb/tb_rr_arb_mux.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Purpose : N-channel arbitrating mux, runtime round-robin or fixed-priority grant, registered output.
// Latency : 1 cycle from input transfer to out_valid; sustains 1 transfer/cycle.
// Backpr. : out_valid && !out_ready freezes the output register and drops every in_ready.
//
// Ports:
//    clk, rst_n          clock (rising edge), asynchronous active-low reset
//    rr_en               1 = round-robin from ptr, 0 = lowest index wins
//    in_valid/in_data    per-channel request; channel i data at [i*WIDTH +: WIDTH]
//    in_ready            per-channel accept, one-hot or zero
//    out_valid/out_data  registered winner data
//    out_sel             index of the channel that supplied out_data
//    out_ready           downstream accept
module rr_arb_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rr_en,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   input  logic               out_ready
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] gnt;
   logic [SELW-1:0] start;
   logic [SELW:0]   idx;
   logic [N-1:0]    shifted;
   logic            found;
   logic            any_vld;
   logic            load;

   assign any_vld = |in_valid;
   assign load    = !out_valid || out_ready;
   assign start   = rr_en ? ptr : '0;

   // Scan start, start+1, ... with explicit wrap so N need not be a power of two.
   // idx carries one extra bit because start+k can reach 2N-2 before the wrap.
   always_comb begin
      gnt     = '0;
      found   = 1'b0;
      idx     = '0;
      shifted = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, start} + (SELW+1)'(k);
         if (idx >= (SELW+1)'(N)) begin
            idx = idx - (SELW+1)'(N);
         end
         shifted = in_valid >> idx;
         if (!found && shifted[0]) begin
            found = 1'b1;
            gnt   = idx[SELW-1:0];
         end
      end
   end

   // Gated by rst_n so no channel sees an accept while the block is held in reset.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         in_ready[i] = rst_n && any_vld && load && (gnt == SELW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load) begin
         if (any_vld) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gnt)*WIDTH +: WIDTH];
            out_sel   <= gnt;
            // Pointer moves past the winner only in round-robin mode; it is
            // left untouched in fixed-priority mode so RR resumes where it was.
            if (rr_en) begin
               ptr <= (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               rr_en;
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_sel;
   logic               out_ready;

   rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .rr_en(rr_en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: what the output stage should hold and where
   // round-robin scanning should start.
   bit          m_vld;
   logic [31:0] m_dat;
   int          m_sel;
   int          m_ptr;
   logic [N-1:0] seen_rdy;

   typedef struct {
      bit         rr;
      logic [3:0] vld;
      bit         ordy;
      logic [3:0] exp_rdy;
      bit         exp_ovld;
      int         exp_sel;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic int ref_grant(input logic [N-1:0] v, input bit rr, input int p);
      int s;
      s = rr ? p : 0;
      for (int k = 0; k < N; k++) begin
         if (v[(s + k) % N]) return (s + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_vld = 0;
      m_dat = '0;
      m_sel = 0;
      m_ptr = 0;
   endtask

   // Called just after a negedge with inputs applied: checks the grant,
   // advances the model across the posedge, then checks the registers.
   task automatic cycle();
      int g;
      bit ld;
      logic [N-1:0] exp_rdy;
      #1;
      g  = ref_grant(in_valid, rr_en, m_ptr);
      ld = !m_vld || out_ready;
      exp_rdy = (g >= 0 && ld) ? N'(1 << g) : '0;
      seen_rdy = in_ready;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      if (ld) begin
         if (g >= 0) begin
            m_vld = 1;
            m_dat = in_data[g*WIDTH +: WIDTH];
            m_sel = g;
            if (rr_en) m_ptr = (g + 1) % N;
         end else begin
            m_vld = 0;
         end
      end
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(m_vld));
      chk("out_sel", 64'(out_sel), 64'(m_sel));
      chk("out_data", 64'(out_data), 64'(m_dat));
   endtask

   initial begin
      // After reset (ptr=0, empty output), data A0+i on every channel.
      tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 1};
      tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2};
      tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};
      tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 0};
      tbl[5]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
      tbl[6]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
      tbl[7]  = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 1};
      tbl[8]  = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 3};
      tbl[9]  = '{1'b1, 4'b0101, 1'b0, 4'b0000, 1'b1, 3};
      tbl[10] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 0};
      tbl[11] = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2};
      tbl[12] = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 0};
      tbl[13] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0};
      tbl[14] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 0};
      tbl[15] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2};
      tbl[16] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2};
      tbl[17] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 3};

      // Reset held with random inputs.
      rst_n     = 1'b0;
      rr_en     = 1'($urandom);
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom);
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_sel", 64'(out_sel), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);

      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + i;
      rst_n = 1'b1;

      // Directed vectors.
      for (int r = 0; r < 18; r++) begin
         rr_en     = tbl[r].rr;
         in_valid  = tbl[r].vld;
         out_ready = tbl[r].ordy;
         cycle();
         chk($sformatf("tbl%0d_rdy", r), 64'(seen_rdy), 64'(tbl[r].exp_rdy));
         chk($sformatf("tbl%0d_ovld", r), 64'(out_valid), 64'(tbl[r].exp_ovld));
         chk($sformatf("tbl%0d_sel", r), 64'(out_sel), 64'(tbl[r].exp_sel));
         chk($sformatf("tbl%0d_data", r), 64'(out_data), 64'(32'hA0 + tbl[r].exp_sel));
      end

      // Backpressure: load 0x1234 from ch2, stall 5 cycles, then ch3 next.
      in_data[2*WIDTH +: WIDTH] = 32'h1234;
      rr_en = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
      cycle();
      chk("bp_load_sel", 64'(out_sel), 64'd2);
      in_valid = 4'b1111; out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("bp_rdy", 64'(seen_rdy), 64'd0);
         chk("bp_data", 64'(out_data), 64'h1234);
         chk("bp_sel", 64'(out_sel), 64'd2);
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_release_rdy", 64'(seen_rdy), 64'b1000);
      chk("bp_release_sel", 64'(out_sel), 64'd3);

      // Async reset between edges while output is valid.
      chk("ar_pre_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_out_data", 64'(out_data), 64'd0);
      chk("ar_out_sel", 64'(out_sel), 64'd0);
      chk("ar_in_ready", 64'(in_ready), 64'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rr_en = 1'($urandom); in_valid = N'($urandom); out_ready = 1'($urandom);
         #1;
         chk("ar_hold_valid", 64'(out_valid), 64'd0);
         chk("ar_hold_rdy", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1; rr_en = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      cycle();
      chk("ar_first_grant", 64'(seen_rdy), 64'b0001);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         rr_en     = ($urandom_range(0, 3) != 0);
         in_valid  = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
